// File: rtl/vend_pkg.sv
// Shared types and constants for the coin accumulator datapath.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Channel 0 sits in the low byte and is the largest denomination.
    localparam logic [23:0] DEFAULT_COIN_VALUES = {8'd1, 8'd5, 8'd10};

    function automatic int coin_sum_width(input int num_coin, input int value_w);
        return value_w + $clog2(num_coin) + 1;
    endfunction

endpackage

// File: rtl/coin_accumulator_if.sv
// Handshake bundle between the debouncers, the accumulator and the dispense logic.
interface coin_accumulator_if #(
    parameter int NUM_COIN = 3,
    parameter int VALUE_W  = 8
);
    logic [NUM_COIN-1:0] coin_in;
    logic                buy;
    logic [VALUE_W-1:0]  price;
    logic                refund;
    logic [VALUE_W-1:0]  balance;
    logic                vend_ok;
    logic                vend_fail;
    logic                coin_reject;
    logic [NUM_COIN-1:0] change_out;
    logic                busy;

    modport master (
        output coin_in, buy, price, refund,
        input  balance, vend_ok, vend_fail, coin_reject, change_out, busy
    );

    modport slave (
        input  coin_in, buy, price, refund,
        output balance, vend_ok, vend_fail, coin_reject, change_out, busy
    );
endinterface

// File: rtl/edge_detect_vec.sv
// Rising-edge detector for a vector of debounced levels.
// History resets high so a level held across reset release is not seen as an edge.
module edge_detect_vec #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] prev_r;

    // Level history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= {WIDTH{1'b1}};
        end else begin
            prev_r <= level;
        end
    end

    assign rise = level & ~prev_r;
endmodule

// File: rtl/coin_accumulator.sv
// Multi-channel coin credit accumulator with saturating ceiling, purchase
// deduction and a paced greedy change dispenser.
module coin_accumulator
    import vend_pkg::*;
#(
    parameter int                          NUM_COIN    = 3,
    parameter int                          VALUE_W     = 8,
    parameter int                          MAX_VALUE   = 255,
    parameter logic [NUM_COIN*VALUE_W-1:0] COIN_VALUES = DEFAULT_COIN_VALUES,
    parameter int                          PAY_GAP     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    coin_accumulator_if.slave  bus
);
    localparam int CW = coin_sum_width(NUM_COIN, VALUE_W);
    localparam int GW = (PAY_GAP > 1) ? $clog2(PAY_GAP) : 1;

    logic [NUM_COIN+1:0] rise_s;
    logic [NUM_COIN-1:0] coin_rise_s;
    logic                buy_rise_s;
    logic                refund_rise_s;

    state_t              state_r, state_next_s;
    logic [GW-1:0]       gap_cnt_r, gap_cnt_next_s;
    logic [VALUE_W-1:0]  balance_r, balance_next_s;
    logic                vend_ok_r, vend_ok_next_s;
    logic                vend_fail_r, vend_fail_next_s;
    logic                coin_reject_r, coin_reject_next_s;
    logic [NUM_COIN-1:0] change_r, change_next_s;
    logic                busy_r;

    logic [CW-1:0]       coin_sum_s;
    logic [CW-1:0]       candidate_s;
    logic                buy_ok_s;
    logic                use_price_s;
    logic                pay_found_s;
    logic [NUM_COIN-1:0] pay_onehot_s;
    logic [VALUE_W-1:0]  pay_value_s;

    edge_detect_vec #(
        .WIDTH (NUM_COIN + 2)
    ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level ({bus.refund, bus.buy, bus.coin_in}),
        .rise  (rise_s)
    );

    assign coin_rise_s   = rise_s[NUM_COIN-1:0];
    assign buy_rise_s    = rise_s[NUM_COIN];
    assign refund_rise_s = rise_s[NUM_COIN+1];

    // Sum of denominations for every channel that rose this cycle
    always_comb begin
        coin_sum_s = {CW{1'b0}};
        for (int i = 0; i < NUM_COIN; i++) begin
            if (coin_rise_s[i]) begin
                coin_sum_s = coin_sum_s + CW'(COIN_VALUES[i*VALUE_W +: VALUE_W]);
            end else begin
                coin_sum_s = coin_sum_s;
            end
        end
    end

    // Greedy pick: scanning downwards leaves the lowest (largest) fitting channel
    always_comb begin
        pay_found_s  = 1'b0;
        pay_onehot_s = {NUM_COIN{1'b0}};
        pay_value_s  = {VALUE_W{1'b0}};
        for (int i = NUM_COIN - 1; i >= 0; i--) begin
            if (COIN_VALUES[i*VALUE_W +: VALUE_W] <= balance_r) begin
                pay_found_s     = 1'b1;
                pay_onehot_s    = {NUM_COIN{1'b0}};
                pay_onehot_s[i] = 1'b1;
                pay_value_s     = COIN_VALUES[i*VALUE_W +: VALUE_W];
            end else begin
                pay_found_s = pay_found_s;
            end
        end
    end

    assign buy_ok_s    = (balance_r >= bus.price);
    assign use_price_s = buy_rise_s & buy_ok_s;
    assign candidate_s = CW'(balance_r) + coin_sum_s
                       - (use_price_s ? CW'(bus.price) : {CW{1'b0}});

    // Next-state and next-output logic
    always_comb begin
        state_next_s       = state_r;
        gap_cnt_next_s     = gap_cnt_r;
        balance_next_s     = balance_r;
        vend_ok_next_s     = 1'b0;
        vend_fail_next_s   = 1'b0;
        coin_reject_next_s = 1'b0;
        change_next_s      = {NUM_COIN{1'b0}};

        case (state_r)
            IDLE: begin
                if (refund_rise_s) begin
                    state_next_s       = PAY;
                    coin_reject_next_s = |coin_rise_s;
                    vend_fail_next_s   = buy_rise_s;
                end else begin
                    vend_ok_next_s   = use_price_s;
                    vend_fail_next_s = buy_rise_s & ~buy_ok_s;
                    // Overflow drops all of this cycle's coins but keeps the purchase
                    if (candidate_s > CW'(MAX_VALUE)) begin
                        coin_reject_next_s = 1'b1;
                        balance_next_s     = use_price_s ? (balance_r - bus.price) : balance_r;
                    end else begin
                        balance_next_s = candidate_s[VALUE_W-1:0];
                    end
                end
            end
            PAY: begin
                coin_reject_next_s = |coin_rise_s;
                vend_fail_next_s   = buy_rise_s;
                if (pay_found_s) begin
                    change_next_s  = pay_onehot_s;
                    balance_next_s = balance_r - pay_value_s;
                    gap_cnt_next_s = GW'(PAY_GAP - 1);
                    if (PAY_GAP == 1) begin
                        state_next_s = PAY;
                    end else begin
                        state_next_s = GAP;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            GAP: begin
                coin_reject_next_s = |coin_rise_s;
                vend_fail_next_s   = buy_rise_s;
                gap_cnt_next_s     = gap_cnt_r - GW'(1);
                if (gap_cnt_r <= GW'(1)) begin
                    state_next_s = PAY;
                end else begin
                    state_next_s = GAP;
                end
            end
            default: begin
                state_next_s   = IDLE;
                gap_cnt_next_s = {GW{1'b0}};
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            gap_cnt_r     <= {GW{1'b0}};
            balance_r     <= {VALUE_W{1'b0}};
            vend_ok_r     <= 1'b0;
            vend_fail_r   <= 1'b0;
            coin_reject_r <= 1'b0;
            change_r      <= {NUM_COIN{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            gap_cnt_r     <= gap_cnt_next_s;
            balance_r     <= balance_next_s;
            vend_ok_r     <= vend_ok_next_s;
            vend_fail_r   <= vend_fail_next_s;
            coin_reject_r <= coin_reject_next_s;
            change_r      <= change_next_s;
            busy_r        <= (state_next_s != IDLE);
        end
    end

    assign bus.balance     = balance_r;
    assign bus.vend_ok     = vend_ok_r;
    assign bus.vend_fail   = vend_fail_r;
    assign bus.coin_reject = coin_reject_r;
    assign bus.change_out  = change_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_coin_accumulator.sv
// Directed self-checking bench for coin_accumulator with default parameters.
module tb_coin_accumulator;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   bal;

    coin_accumulator_if #(.NUM_COIN(3), .VALUE_W(8)) bus ();

    coin_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_coins(input logic [2:0] mask, input int exp_bal, input logic exp_rej);
        bus.coin_in = mask;
        tick();
        chk("coin_balance", 32'(bus.balance), 32'(exp_bal));
        chk("coin_reject", 32'(bus.coin_reject), 32'(exp_rej));
        bus.coin_in = 3'b000;
        tick();
        chk("coin_reject_clear", 32'(bus.coin_reject), 32'd0);
    endtask

    task automatic do_buy(input int p, input logic exp_ok, input int exp_bal);
        bus.price = 8'(p);
        bus.buy   = 1'b1;
        tick();
        chk("vend_ok", 32'(bus.vend_ok), 32'(exp_ok));
        chk("vend_fail", 32'(bus.vend_fail), 32'(!exp_ok));
        chk("buy_balance", 32'(bus.balance), 32'(exp_bal));
        bus.buy = 1'b0;
        tick();
        chk("vend_pulse_clear", 32'({bus.vend_ok, bus.vend_fail}), 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.coin_in = 3'b000;
        bus.buy     = 1'b0;
        bus.price   = 8'd0;
        bus.refund  = 1'b0;
        repeat (3) tick();
        chk("reset_balance", 32'(bus.balance), 32'd0);
        chk("reset_pulses", 32'({bus.vend_ok, bus.vend_fail, bus.coin_reject, bus.busy}), 32'd0);
        chk("reset_change", 32'(bus.change_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Credit 10, 5, 1, 10
        pulse_coins(3'b001, 10, 1'b0);
        pulse_coins(3'b010, 15, 1'b0);
        pulse_coins(3'b100, 16, 1'b0);
        pulse_coins(3'b001, 26, 1'b0);

        // Purchase then insufficient-credit purchase
        do_buy(20, 1'b1, 6);
        do_buy(20, 1'b0, 6);

        // Build up to 250 and probe the ceiling
        bal = 6;
        for (int i = 0; i < 24; i++) begin
            bal = bal + 10;
            pulse_coins(3'b001, bal, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            bal = bal + 1;
            pulse_coins(3'b100, bal, 1'b0);
        end
        chk("reach_250", 32'(bus.balance), 32'd250);
        pulse_coins(3'b001, 250, 1'b1);
        pulse_coins(3'b010, 255, 1'b0);
        pulse_coins(3'b100, 255, 1'b1);

        // Down to 16, then refund with a coin and a buy mid-refund
        do_buy(239, 1'b1, 16);
        do_buy(0, 1'b1, 16);
        bus.refund = 1'b1;
        tick();
        chk("refund_busy", 32'(bus.busy), 32'd1);
        chk("refund_bal0", 32'(bus.balance), 32'd16);
        bus.refund = 1'b0;
        tick();
        chk("change_10", 32'(bus.change_out), 32'b001);
        chk("change_10_bal", 32'(bus.balance), 32'd6);
        bus.coin_in = 3'b010;
        tick();
        chk("mid_refund_reject", 32'(bus.coin_reject), 32'd1);
        chk("mid_refund_bal", 32'(bus.balance), 32'd6);
        chk("gap_quiet1", 32'(bus.change_out), 32'd0);
        bus.coin_in = 3'b000;
        bus.price   = 8'd1;
        bus.buy     = 1'b1;
        tick();
        chk("mid_refund_vend_fail", 32'({bus.vend_ok, bus.vend_fail}), 32'b01);
        chk("mid_refund_bal2", 32'(bus.balance), 32'd6);
        bus.buy = 1'b0;
        tick();
        chk("gap_quiet2", 32'(bus.change_out), 32'd0);
        tick();
        chk("change_5", 32'(bus.change_out), 32'b010);
        chk("change_5_bal", 32'(bus.balance), 32'd1);
        repeat (3) tick();
        chk("gap_quiet3", 32'(bus.change_out), 32'd0);
        tick();
        chk("change_1", 32'(bus.change_out), 32'b100);
        chk("change_1_bal", 32'(bus.balance), 32'd0);
        repeat (3) tick();
        chk("busy_held", 32'(bus.busy), 32'd1);
        tick();
        chk("busy_drop", 32'(bus.busy), 32'd0);
        chk("refund_done_bal", 32'(bus.balance), 32'd0);

        // Simultaneous coins and purchase
        pulse_coins(3'b001, 10, 1'b0);
        pulse_coins(3'b100, 11, 1'b0);
        pulse_coins(3'b100, 12, 1'b0);
        bus.price   = 8'd12;
        bus.buy     = 1'b1;
        bus.coin_in = 3'b011;
        tick();
        chk("combo_ok", 32'({bus.vend_ok, bus.vend_fail}), 32'b10);
        chk("combo_ok_bal", 32'(bus.balance), 32'd15);
        bus.buy     = 1'b0;
        bus.coin_in = 3'b000;
        tick();
        do_buy(3, 1'b1, 12);
        bus.price   = 8'd13;
        bus.buy     = 1'b1;
        bus.coin_in = 3'b011;
        tick();
        chk("combo_fail", 32'({bus.vend_ok, bus.vend_fail}), 32'b01);
        chk("combo_fail_bal", 32'(bus.balance), 32'd27);
        bus.buy     = 1'b0;
        bus.coin_in = 3'b000;
        tick();

        // Abort a refund with reset while in the gap
        bus.refund = 1'b1;
        tick();
        bus.refund = 1'b0;
        tick();
        chk("abort_change_10", 32'(bus.change_out), 32'b001);
        chk("abort_bal", 32'(bus.balance), 32'd17);
        tick();
        #3;
        rst_n       = 1'b0;
        bus.coin_in = 3'b001;
        #1;
        chk("async_balance", 32'(bus.balance), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("reset_no_change", 32'(bus.change_out), 32'd0);
        end
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_coin_bal", 32'(bus.balance), 32'd0);
            chk("held_coin_quiet", 32'({bus.coin_reject, bus.busy, bus.change_out}), 32'd0);
        end
        bus.coin_in = 3'b000;
        tick();
        pulse_coins(3'b001, 10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
